stepper_phase_driver: RTL

//  Receiving end of the step/direction interface driven by the master controller.

---
 rtl/stepper_phase_driver.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/stepper_phase_driver.sv
// Step/direction receiver for one stepper axis.
// Half/full-step coil sequencing, soft limits, overspeed guard, hold timeout.
module stepper_phase_driver #(
  parameter int                      POS_W        = 16,
  parameter logic signed [POS_W-1:0] POS_MAX      = 16'sd8000,
  parameter logic signed [POS_W-1:0] POS_MIN      = -16'sd8000,
  parameter int                      MIN_GAP      = 4000,
  parameter int                      HOLD_TIMEOUT = 24000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    step_pulse,
  input  logic                    step_dir,
  input  logic                    enable,
  input  logic                    half_step,
  input  logic                    zero_pos,
  input  logic                    clear_err,
  output logic [3:0]              coil,
  output logic signed [POS_W-1:0] position,
  output logic                    step_done,
  output logic                    limit_hit,
  output logic                    overspeed_err,
  output logic                    idle
);

  localparam int GW = $clog2(MIN_GAP + 1);
  localparam int TW = $clog2(HOLD_TIMEOUT + 1);

  logic                    r_sp1, r_sp2, r_sp3;
  logic                    r_dir1, r_dir2;
  logic signed [POS_W-1:0] r_pos;
  logic [2:0]              r_idx;
  logic                    r_done, r_lim, r_err;
  logic [GW-1:0]           r_gap;
  logic [TW-1:0]           r_tmr;
  logic                    r_idle;

  logic       w_req, w_live, w_gap_ok, w_at_lim;
  logic       w_ovs, w_lim, w_acc;
  logic [2:0] w_inc, w_idx_nx;
  logic [3:0] w_tbl;

  assign w_req    = r_sp2 & ~r_sp3;
  assign w_live   = w_req & enable & ~zero_pos;
  assign w_gap_ok = (r_gap >= GW'(MIN_GAP));
  assign w_at_lim = r_dir2 ? (r_pos == POS_MIN) : (r_pos == POS_MAX);
  assign w_ovs    = w_live & ~w_gap_ok;
  assign w_lim    = w_live & w_gap_ok & w_at_lim;
  assign w_acc    = w_live & w_gap_ok & ~w_at_lim;
  assign w_inc    = half_step ? 3'd1 : 3'd2;
  assign w_idx_nx = r_dir2 ? (r_idx - w_inc) : (r_idx + w_inc);

  // two-stage synchronizers plus edge-detect history for the step pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp1  <= 1'b0;
      r_sp2  <= 1'b0;
      r_sp3  <= 1'b0;
      r_dir1 <= 1'b0;
      r_dir2 <= 1'b0;
    end else begin
      r_sp1  <= step_pulse;
      r_sp2  <= r_sp1;
      r_sp3  <= r_sp2;
      r_dir1 <= step_dir;
      r_dir2 <= r_dir1;
    end
  end

  // position, phase index and per-request status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos  <= '0;
      r_idx  <= 3'd0;
      r_done <= 1'b0;
      r_lim  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_acc;
      r_lim  <= w_lim;
      if (zero_pos)
        r_pos <= '0;
      else if (w_acc)
        r_pos <= r_dir2 ? r_pos - POS_W'(1) : r_pos + POS_W'(1);
      if (w_acc)
        r_idx <= w_idx_nx;
      if (w_ovs)
        r_err <= 1'b1;
      else if (clear_err)
        r_err <= 1'b0;
    end
  end

  // cycles since last accepted step, saturating so the first step is legal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_gap <= GW'(MIN_GAP);
    else if (w_acc)
      r_gap <= '0;
    else if (r_gap < GW'(MIN_GAP))
      r_gap <= r_gap + 1'b1;
  end

  // hold timer: drop coils after a long stretch with no accepted step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr  <= '0;
      r_idle <= 1'b1;
    end else if (w_acc) begin
      r_tmr  <= '0;
      r_idle <= 1'b0;
    end else if (!r_idle) begin
      if (r_tmr == TW'(HOLD_TIMEOUT))
        r_idle <= 1'b1;
      else
        r_tmr <= r_tmr + 1'b1;
    end
  end

  // half-step phase table, gated by enable and hold state
  always_comb begin
    w_tbl = 4'b0000;
    unique case (r_idx)
      3'd0: w_tbl = 4'b1000;
      3'd1: w_tbl = 4'b1100;
      3'd2: w_tbl = 4'b0100;
      3'd3: w_tbl = 4'b0110;
      3'd4: w_tbl = 4'b0010;
      3'd5: w_tbl = 4'b0011;
      3'd6: w_tbl = 4'b0001;
      3'd7: w_tbl = 4'b1001;
    endcase
    coil = (enable & ~r_idle) ? w_tbl : 4'b0000;
  end

  assign position      = r_pos;
  assign step_done     = r_done;
  assign limit_hit     = r_lim;
  assign overspeed_err = r_err;
  assign idle          = r_idle;

endmodule
